fall_tick_receiver: RTL and testbench

Gravity-side consumer of the frame pulse train from the frame clock generator, and the producer of its `Fall_Count` speed input. It edge-detects the pulse and divides it down to piece-drop requests. Each request is handed to the piece-motion FSM with a request/acknowledge handshake. It also accumulates cleared lines into a level, and converts the level into `Fall_Count`, closing the speed-up loop.

---
 rtl/fall_tick_receiver.sv | 223 ++++++++++++++++++++++
 tb/tb_fall_tick_receiver.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fall_tick_receiver.sv
// -----------------------------------------------------------------------------
// fall_tick_receiver
//
// Gravity-side consumer of the frame pulse train. Edge-detects frame_tick,
// divides the ticks down to piece-drop requests (request/acknowledge with the
// piece-motion FSM), accumulates cleared lines into a level and converts the
// level into the Fall_Count speed value fed back to the frame clock generator.
//
// Optional feature macro: FALL_OVERRUN_EN
//   defined   - Overrun is a sticky flag raised when a drop comes due while a
//               request is still pending and not acknowledged in that cycle.
//   undefined - Overrun is tied low; missed drops are silently discarded.
// -----------------------------------------------------------------------------
module fall_tick_receiver #(
    parameter int unsigned TICKS_PER_DROP = 4,   // 1..15 frame pulses per drop
    parameter int unsigned FALL_STEP      = 5,   // Fall_Count increment per level
    parameter int unsigned LEVEL_MAX      = 15   // Level saturation value
) (
    input  logic       frame_clk_in,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       Enable,
    input  logic       Soft_Drop,
    input  logic       Clear_Valid,
    input  logic [2:0] Lines_Cleared,
    input  logic       Drop_Ack,
    output logic       Drop_Req,
    output logic [6:0] Fall_Count,
    output logic [3:0] Level,
    output logic       Overrun
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [3:0] DIV_NORMAL    = TICKS_PER_DROP[3:0];
    localparam logic [3:0] LEVEL_MAX_L   = LEVEL_MAX[3:0];
    localparam logic [3:0] LINES_PER_LVL = 4'd10;
    localparam logic [2:0] LINES_CAP     = 3'd4;
    localparam logic [31:0] SPEED_CAP    = 32'd127;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_REQ   = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State registers and their next-state values
    // -------------------------------------------------------------------------
    logic       tick_q,         tick_d;
    state_t     state_q,        state_d;
    logic [3:0] tick_cnt_q,     tick_cnt_d;
    logic [3:0] lines_in_lvl_q, lines_in_lvl_d;
    logic [3:0] level_q,        level_d;
    logic [6:0] fall_count_q,   fall_count_d;
    logic       overrun_q,      overrun_d;

    // Intermediate combinational values
    logic       tick;
    logic [3:0] div;
    logic [4:0] cnt_inc;
    logic       drop_due;
    logic [3:0] cnt_after_tick;
    logic [2:0] lines_eff;
    logic [3:0] lines_sum;
    logic [31:0] speed_raw;

    // -------------------------------------------------------------------------
    // Rising-edge detect on the frame pulse train. The previous-sample flop
    // resets to 1 because the generator output is high right after reset;
    // this keeps the first cycle out of reset from looking like a tick.
    // -------------------------------------------------------------------------
    always_comb begin
        tick   = frame_tick & ~tick_q;
        tick_d = frame_tick;
    end

    // -------------------------------------------------------------------------
    // Drop divider: decide whether this tick completes a drop interval and
    // what the tick counter becomes if a tick is counted this cycle.
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        div            = Soft_Drop ? 4'd1 : DIV_NORMAL;
        cnt_inc        = {1'b0, tick_cnt_q} + 5'd1;
        drop_due       = 1'b0;
        cnt_after_tick = tick_cnt_q;
        if (tick) begin
            // Compare at 5 bits so a counter of 15 cannot wrap to 0.
            if (cnt_inc >= {1'b0, div}) begin
                drop_due       = 1'b1;
                cnt_after_tick = 4'd0;
            end else begin
                cnt_after_tick = cnt_inc[3:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Drop FSM next-state logic: IDLE while disabled, COUNT between drops,
    // REQ while a drop request waits for the piece FSM.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        if (!Enable) begin
            // Disabling abandons any pending request immediately.
            state_d    = ST_IDLE;
            tick_cnt_d = 4'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    tick_cnt_d = 4'd0;
                    state_d    = ST_COUNT;
                end
                ST_COUNT: begin
                    tick_cnt_d = cnt_after_tick;
                    if (drop_due) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Ticks keep being counted while the request is pending.
                    tick_cnt_d = cnt_after_tick;
                    if (Drop_Ack && !drop_due) begin
                        state_d = ST_COUNT;
                    end
                    // Ack plus a fresh due drop re-arms the request; a due
                    // drop without ack is discarded. Both stay in REQ.
                end
                default: begin
                    state_d    = ST_IDLE;
                    tick_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Overrun flag: sticky record of a drop lost while a request was pending.
    // -------------------------------------------------------------------------
    always_comb begin
`ifdef FALL_OVERRUN_EN
        overrun_d = overrun_q;
        if (!Enable) begin
            overrun_d = 1'b0;
        end else if ((state_q == ST_REQ) && drop_due && !Drop_Ack) begin
            overrun_d = 1'b1;
        end
`else
        overrun_d = 1'b0;
`endif
    end

    // -------------------------------------------------------------------------
    // Line accounting and level: every ten cleared lines raise the level by
    // one (saturating), the remainder carries over even at the top level.
    // Clear events are counted whether or not the game is enabled.
    // -------------------------------------------------------------------------
    always_comb begin
        lines_eff      = (Lines_Cleared > LINES_CAP) ? LINES_CAP : Lines_Cleared;
        lines_sum      = lines_in_lvl_q + {1'b0, lines_eff};
        lines_in_lvl_d = lines_in_lvl_q;
        level_d        = level_q;
        if (Clear_Valid) begin
            if (lines_sum >= LINES_PER_LVL) begin
                lines_in_lvl_d = lines_sum - LINES_PER_LVL;
                if (level_q < LEVEL_MAX_L) begin
                    level_d = level_q + 4'd1;
                end
            end else begin
                lines_in_lvl_d = lines_sum;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Speed value: derived from the next level so Fall_Count and Level change
    // on the same edge.
    // -------------------------------------------------------------------------
    always_comb begin
        speed_raw    = 32'(level_d) * FALL_STEP;
        fall_count_d = (speed_raw > SPEED_CAP) ? 7'd127 : speed_raw[6:0];
    end

    // -------------------------------------------------------------------------
    // State register with synchronous, active-high reset.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge frame_clk_in) begin
        if (Reset) begin
            tick_q         <= 1'b1;
            state_q        <= ST_IDLE;
            tick_cnt_q     <= 4'd0;
            lines_in_lvl_q <= 4'd0;
            level_q        <= 4'd0;
            fall_count_q   <= 7'd0;
            overrun_q      <= 1'b0;
        end else begin
            tick_q         <= tick_d;
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            lines_in_lvl_q <= lines_in_lvl_d;
            level_q        <= level_d;
            fall_count_q   <= fall_count_d;
            overrun_q      <= overrun_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all straight from flops.
    // -------------------------------------------------------------------------
    always_comb begin
        Drop_Req   = (state_q == ST_REQ);
        Fall_Count = fall_count_q;
        Level      = level_q;
        Overrun    = overrun_q;
    end

endmodule

// File: tb/tb_fall_tick_receiver.sv
// -----------------------------------------------------------------------------
// tb_fall_tick_receiver
//
// Self-checking bench for fall_tick_receiver: directed scenarios followed by
// randomized stimulus, all compared against a behavioural model that tracks
// ticks since the last drop, a pending-request flag and the total number of
// cleared lines (level = total / 10, saturated).
// Honours FALL_OVERRUN_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fall_tick_receiver;

    localparam int unsigned TICKS_PER_DROP = 4;
    localparam int unsigned FALL_STEP      = 5;
    localparam int unsigned LEVEL_MAX      = 15;

    logic       frame_clk_in = 1'b0;
    logic       Reset        = 1'b1;
    logic       frame_tick   = 1'b1;
    logic       Enable       = 1'b0;
    logic       Soft_Drop    = 1'b0;
    logic       Clear_Valid  = 1'b0;
    logic [2:0] Lines_Cleared = 3'd0;
    logic       Drop_Ack     = 1'b0;
    logic       Drop_Req;
    logic [6:0] Fall_Count;
    logic [3:0] Level;
    logic       Overrun;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    // Behavioural reference state
    bit          m_prev_ft     = 1'b1;
    bit          m_running     = 1'b0;
    int unsigned m_ticks       = 0;
    bit          m_pending     = 1'b0;
    bit          m_overrun     = 1'b0;
    int unsigned m_total_lines = 0;

    fall_tick_receiver #(
        .TICKS_PER_DROP(TICKS_PER_DROP),
        .FALL_STEP     (FALL_STEP),
        .LEVEL_MAX     (LEVEL_MAX)
    ) dut (
        .frame_clk_in (frame_clk_in),
        .Reset        (Reset),
        .frame_tick   (frame_tick),
        .Enable       (Enable),
        .Soft_Drop    (Soft_Drop),
        .Clear_Valid  (Clear_Valid),
        .Lines_Cleared(Lines_Cleared),
        .Drop_Ack     (Drop_Ack),
        .Drop_Req     (Drop_Req),
        .Fall_Count   (Fall_Count),
        .Level        (Level),
        .Overrun      (Overrun)
    );

    always #5 frame_clk_in = ~frame_clk_in;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned exp_level();
        int unsigned l;
        l = m_total_lines / 10;
        return (l > LEVEL_MAX) ? LEVEL_MAX : l;
    endfunction

    function automatic int unsigned exp_fall_count();
        int unsigned s;
        s = exp_level() * FALL_STEP;
        return (s > 127) ? 127 : s;
    endfunction

    // Advance the reference by one clock edge using the inputs now applied.
    task automatic model_edge();
        bit tick_now;
        bit due;
        if (Reset) begin
            m_prev_ft     = 1'b1;
            m_running     = 1'b0;
            m_ticks       = 0;
            m_pending     = 1'b0;
            m_overrun     = 1'b0;
            m_total_lines = 0;
            return;
        end
        tick_now  = frame_tick && !m_prev_ft;
        m_prev_ft = frame_tick;
        if (!Enable) begin
            m_running = 1'b0;
            m_ticks   = 0;
            m_pending = 1'b0;
            m_overrun = 1'b0;
        end else if (!m_running) begin
            m_running = 1'b1;
        end else begin
            due = 1'b0;
            if (tick_now) begin
                m_ticks++;
                if (m_ticks >= (Soft_Drop ? 1 : TICKS_PER_DROP)) begin
                    m_ticks = 0;
                    due     = 1'b1;
                end
            end
            if (m_pending) begin
                if (Drop_Ack) begin
                    m_pending = due;
                end else if (due) begin
`ifdef FALL_OVERRUN_EN
                    m_overrun = 1'b1;
`endif
                end
            end else begin
                m_pending = due;
            end
        end
        if (Clear_Valid) begin
            m_total_lines += (Lines_Cleared > 3'd4) ? 4 : int'(Lines_Cleared);
        end
    endtask

    // One clock: inputs are already driven; update model, take the edge,
    // then compare all outputs 1 time unit later.
    task automatic apply();
        model_edge();
        @(posedge frame_clk_in);
        #1;
        check("drop_req",   Drop_Req,   m_pending);
        check("overrun",    Overrun,    m_overrun);
        check("level",      Level,      exp_level());
        check("fall_count", Fall_Count, exp_fall_count());
    endtask

    // One rising edge of frame_tick: a low cycle followed by a high cycle.
    task automatic tick_edge();
        frame_tick = 1'b0;
        apply();
        frame_tick = 1'b1;
        apply();
    endtask

    task automatic do_reset();
        Reset       = 1'b1;
        Enable      = 1'b0;
        frame_tick  = 1'b1;
        Clear_Valid = 1'b0;
        Drop_Ack    = 1'b0;
        Soft_Drop   = 1'b0;
        apply();
        Reset = 1'b0;
    endtask

    initial begin
        // ---- Reset / start: Reset for two cycles with frame_tick high ------
        Reset      = 1'b1;
        frame_tick = 1'b1;
        apply();
        apply();
        check("reset_drop_req",   Drop_Req,   0);
        check("reset_level",      Level,      0);
        check("reset_fall_count", Fall_Count, 0);
        check("reset_overrun",    Overrun,    0);
        Reset  = 1'b0;
        Enable = 1'b1;
        apply();
        apply();
        check("no_spurious_tick", Drop_Req, 0);

        // ---- Normal drop: 4 tick edges, request one cycle after the 4th ----
        for (int i = 0; i < 3; i++) tick_edge();
        check("before_4th_edge", Drop_Req, 0);
        tick_edge();
        check("after_4th_edge", Drop_Req, 1);
        apply();
        apply();   // frame_tick held high: no further ticks
        check("held_high_one_tick", Drop_Req, 1);
        Drop_Ack = 1'b1;
        apply();
        Drop_Ack = 1'b0;
        check("ack_clears_req", Drop_Req, 0);

        // ---- Soft drop: request on every edge, ack meets next due drop -----
        Soft_Drop = 1'b1;
        tick_edge();
        check("soft_req", Drop_Req, 1);
        frame_tick = 1'b0;
        apply();
        frame_tick = 1'b1;
        Drop_Ack   = 1'b1;
        apply();
        check("ack_and_due_req",     Drop_Req, 1);
        check("ack_and_due_overrun", Overrun,  0);
        apply();   // ack with no new drop due
        Drop_Ack = 1'b0;
        check("soft_ack_clears", Drop_Req, 0);

        // ---- Soft drop rising mid-count ------------------------------------
        Soft_Drop = 1'b0;
        tick_edge();
        tick_edge();
        check("mid_count_no_req", Drop_Req, 0);
        Soft_Drop = 1'b1;
        tick_edge();
        check("mid_count_soft_req", Drop_Req, 1);
        Drop_Ack = 1'b1;
        apply();
        Drop_Ack  = 1'b0;
        Soft_Drop = 1'b0;

        // ---- Overrun: never ack, 8 tick edges ------------------------------
        for (int i = 0; i < 8; i++) tick_edge();
        check("overrun_req_held", Drop_Req, 1);
`ifdef FALL_OVERRUN_EN
        check("overrun_set", Overrun, 1);
`else
        check("overrun_tied_low", Overrun, 0);
`endif
        Enable = 1'b0;
        apply();
        check("disable_overrun", Overrun,  0);
        check("disable_req",     Drop_Req, 0);

        // ---- Levelling: 4, 4, 3 lines -> level 1, remainder 1 --------------
        do_reset();
        Clear_Valid = 1'b1;
        Lines_Cleared = 3'd4; apply();
        Lines_Cleared = 3'd4; apply();
        Lines_Cleared = 3'd3; apply();
        check("lvl1_level",      Level,      1);
        check("lvl1_fall_count", Fall_Count, 5);
        Lines_Cleared = 3'd4; apply();
        Lines_Cleared = 3'd4; apply();
        check("remainder_9_level", Level, 1);
        Lines_Cleared = 3'd1; apply();
        check("lvl2_level",      Level,      2);
        check("lvl2_fall_count", Fall_Count, 10);
        Clear_Valid = 1'b0;
        apply();

        // ---- Saturation: 40 strobes of 7 lines (counted as 4) --------------
        do_reset();
        Clear_Valid   = 1'b1;
        Lines_Cleared = 3'd7;
        for (int i = 0; i < 40; i++) apply();
        Clear_Valid = 1'b0;
        apply();
        check("sat_level",      Level,      15);
        check("sat_fall_count", Fall_Count, 75);

        // ---- Randomized operation ------------------------------------------
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            Reset = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 2) == 0) frame_tick = ~frame_tick;
            if ($urandom_range(0, 99) == 0) Enable = ~Enable;
            else if (!Enable && $urandom_range(0, 9) == 0) Enable = 1'b1;
            if ($urandom_range(0, 49) == 0) Soft_Drop = ~Soft_Drop;
            Drop_Ack      = ($urandom_range(0, 5) == 0);
            Clear_Valid   = ($urandom_range(0, 7) == 0);
            Lines_Cleared = 3'($urandom_range(0, 7));
            apply();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
